branch_seq_ctrl: RTL and testbench

BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

---
 rtl/branch_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_branch_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_seq_ctrl
// Purpose  : Branch resolution sequencer for a 5-stage pipeline with branches
//            resolved in ID. It decodes the ID-stage branch and computes the
//            stall depth from EX/MEM producers. It sequences
//            IDLE -> STALL -> RESOLVE and drives the comparator forwarding
//            selects and the redirect/flush signals. It also counts taken
//            branches with a saturating counter.
// Ports    : Clk, Rst (async, active-low)
//            ID_*   : branch instruction in ID (valid, opcode, bit16, rs, rt)
//            EX_* / MEM_* / WB_* : producer descriptors of later stages
//            CmpOut : branch comparator result
//            Stall, FwdA, FwdB, PCSrc, FlushIF, TakenCnt : control outputs
// Revision : 1.0  initial release
// ============================================================================
module branch_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ID_Valid,
  input  logic [5:0]       ID_Opcode,
  input  logic             ID_IBit16,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_Rd,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_Rd,
  input  logic             CmpOut,
  output logic             Stall,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic             PCSrc,
  output logic             FlushIF,
  output logic [CNT_W-1:0] TakenCnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STALL   = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_MEM = 2'b01;
  localparam logic [1:0] c_FWD_WB  = 2'b10;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] taken_q, taken_d;

  logic       w_regimm;
  logic       w_is_branch;
  logic       w_use_rt;
  logic       w_ex_a, w_mem_a, w_wb_a;
  logic       w_ex_b, w_mem_b, w_wb_b;
  logic [1:0] w_need_a, w_need_b, w_need;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_stall, w_resolve;

  // Stall cycles required for one operand given its EX/MEM match flags.
  function automatic logic [1:0] need_f(input logic ex_m, input logic mem_m);
    if (ex_m && EX_MemRead)        need_f = 2'd2;
    else if (ex_m)                 need_f = 2'd1;
    else if (mem_m && MEM_MemRead) need_f = 2'd1;
    else                           need_f = 2'd0;
  endfunction

  // Comparator operand source for one operand given its MEM/WB match flags.
  function automatic logic [1:0] fwd_f(input logic used, input logic mem_m,
                                       input logic wb_m);
    if (!used)                         fwd_f = c_FWD_RF;
    else if (mem_m && !MEM_MemRead)    fwd_f = c_FWD_MEM;
    else if (wb_m)                     fwd_f = c_FWD_WB;
    else                               fwd_f = c_FWD_RF;
  endfunction

  // BGEZ (bit16=1) and BLTZ (bit16=0) are both branches; bit 16 only steers
  // the comparator, so either polarity qualifies the REGIMM opcode here.
  assign w_regimm    = (ID_Opcode == 6'd1) && (ID_IBit16 || !ID_IBit16);
  assign w_is_branch = ID_Valid && (w_regimm || (ID_Opcode == 6'd4) ||
                       (ID_Opcode == 6'd5) || (ID_Opcode == 6'd6) ||
                       (ID_Opcode == 6'd7));
  assign w_use_rt    = (ID_Opcode == 6'd4) || (ID_Opcode == 6'd5);

  // A write to r0 never creates a dependency.
  assign w_ex_a  = EX_RegWrite  && (EX_Rd  == ID_Rs) && (EX_Rd  != 5'd0);
  assign w_mem_a = MEM_RegWrite && (MEM_Rd == ID_Rs) && (MEM_Rd != 5'd0);
  assign w_wb_a  = WB_RegWrite  && (WB_Rd  == ID_Rs) && (WB_Rd  != 5'd0);
  assign w_ex_b  = EX_RegWrite  && (EX_Rd  == ID_Rt) && (EX_Rd  != 5'd0);
  assign w_mem_b = MEM_RegWrite && (MEM_Rd == ID_Rt) && (MEM_Rd != 5'd0);
  assign w_wb_b  = WB_RegWrite  && (WB_Rd  == ID_Rt) && (WB_Rd  != 5'd0);

  assign w_need_a = need_f(w_ex_a, w_mem_a);
  assign w_need_b = w_use_rt ? need_f(w_ex_b, w_mem_b) : 2'd0;
  assign w_need   = (w_need_a > w_need_b) ? w_need_a : w_need_b;

  assign w_fwd_a  = w_is_branch ? fwd_f(1'b1,     w_mem_a, w_wb_a) : c_FWD_RF;
  assign w_fwd_b  = w_is_branch ? fwd_f(w_use_rt, w_mem_b, w_wb_b) : c_FWD_RF;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_stall   = 1'b0;
    w_resolve = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_is_branch) begin
          if (w_need == 2'd0) begin
            w_resolve = 1'b1;
          end else begin
            w_stall = 1'b1;
            cnt_d   = w_need - 2'd1;
            state_d = (w_need == 2'd2) ? S_STALL : S_RESOLVE;
          end
        end
      end
      S_STALL: begin
        // The stall depth was fixed on entry; live hazard inputs are ignored.
        w_stall = 1'b1;
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = S_RESOLVE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESOLVE: begin
        w_resolve = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    taken_d = taken_q;
    if (w_resolve && CmpOut && (taken_q != {CNT_W{1'b1}})) begin
      taken_d = taken_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      taken_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end

  // Outputs are gated by reset so that a branch sitting in ID cannot raise
  // Stall or select forwarding while the sequencer is held in reset.
  assign Stall    = Rst && w_stall;
  assign PCSrc    = Rst && w_resolve && CmpOut;
  assign FlushIF  = PCSrc;
  assign FwdA     = Rst ? w_fwd_a : c_FWD_RF;
  assign FwdB     = Rst ? w_fwd_b : c_FWD_RF;
  assign TakenCnt = taken_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_seq_ctrl
// Purpose  : Self-checking bench for branch_seq_ctrl: vector table, directed
//            multi-cycle sequences, reset/saturation cases and a randomized run
//            against a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_seq_ctrl;

  localparam int CNT_W = 16;

  logic             Clk;
  logic             Rst;
  logic             ID_Valid;
  logic [5:0]       ID_Opcode;
  logic             ID_IBit16;
  logic [4:0]       ID_Rs, ID_Rt;
  logic             EX_RegWrite, EX_MemRead;
  logic [4:0]       EX_Rd;
  logic             MEM_RegWrite, MEM_MemRead;
  logic [4:0]       MEM_Rd;
  logic             WB_RegWrite;
  logic [4:0]       WB_Rd;
  logic             CmpOut;
  logic             Stall;
  logic [1:0]       FwdA, FwdB;
  logic             PCSrc, FlushIF;
  logic [CNT_W-1:0] TakenCnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_taken = 0;

  branch_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .ID_Valid(ID_Valid), .ID_Opcode(ID_Opcode), .ID_IBit16(ID_IBit16),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd),
    .CmpOut(CmpOut),
    .Stall(Stall), .FwdA(FwdA), .FwdB(FwdB),
    .PCSrc(PCSrc), .FlushIF(FlushIF), .TakenCnt(TakenCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit       valid;
    bit [5:0] op;
    bit [4:0] rs, rt;
    bit       exrw, exmr;
    bit [4:0] exrd;
    bit       memrw, memmr;
    bit [4:0] memrd;
    bit       wbrw;
    bit [4:0] wbrd;
    bit       cmp;
    bit       e_stall, e_pc;
    bit [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_outs(input string tag, input bit st, input bit pc,
                            input bit [1:0] fa, input bit [1:0] fb);
    chk({tag, ".Stall"},   Stall,   st);
    chk({tag, ".PCSrc"},   PCSrc,   pc);
    chk({tag, ".FlushIF"}, FlushIF, pc);
    chk({tag, ".FwdA"},    FwdA,    fa);
    chk({tag, ".FwdB"},    FwdB,    fb);
  endtask

  task automatic clear_inputs();
    ID_Valid = 0; ID_Opcode = 0; ID_IBit16 = 0; ID_Rs = 0; ID_Rt = 0;
    EX_RegWrite = 0; EX_MemRead = 0; EX_Rd = 0;
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_Rd = 0;
    WB_RegWrite = 0; WB_Rd = 0; CmpOut = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    ID_Valid = v.valid; ID_Opcode = v.op; ID_IBit16 = 1'b1;
    ID_Rs = v.rs; ID_Rt = v.rt;
    EX_RegWrite = v.exrw; EX_MemRead = v.exmr; EX_Rd = v.exrd;
    MEM_RegWrite = v.memrw; MEM_MemRead = v.memmr; MEM_Rd = v.memrd;
    WB_RegWrite = v.wbrw; WB_Rd = v.wbrd; CmpOut = v.cmp;
  endtask

  function automatic vec_t mk(bit valid, bit [5:0] op, bit [4:0] rs, bit [4:0] rt,
                              bit exrw, bit exmr, bit [4:0] exrd,
                              bit memrw, bit memmr, bit [4:0] memrd,
                              bit wbrw, bit [4:0] wbrd, bit cmp,
                              bit e_stall, bit e_pc, bit [1:0] e_fa, bit [1:0] e_fb);
    vec_t v;
    v.valid = valid; v.op = op; v.rs = rs; v.rt = rt;
    v.exrw = exrw; v.exmr = exmr; v.exrd = exrd;
    v.memrw = memrw; v.memmr = memmr; v.memrd = memrd;
    v.wbrw = wbrw; v.wbrd = wbrd; v.cmp = cmp;
    v.e_stall = e_stall; v.e_pc = e_pc; v.e_fa = e_fa; v.e_fb = e_fb;
    return v;
  endfunction

  // ---- reference model, written from the architectural rules ----
  function automatic bit m_is_branch();
    return ID_Valid && (ID_Opcode inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7});
  endfunction

  function automatic bit m_hit(bit rw, bit [4:0] rd, bit [4:0] r);
    return rw && (rd == r) && (rd != 0);
  endfunction

  function automatic int m_need(bit [4:0] r);
    if (m_hit(EX_RegWrite, EX_Rd, r)) return EX_MemRead ? 2 : 1;
    if (m_hit(MEM_RegWrite, MEM_Rd, r) && MEM_MemRead) return 1;
    return 0;
  endfunction

  function automatic int m_stalls();
    int a, b;
    a = m_need(ID_Rs);
    b = (ID_Opcode inside {6'd4, 6'd5}) ? m_need(ID_Rt) : 0;
    return (a > b) ? a : b;
  endfunction

  function automatic bit [1:0] m_fwd(bit is_rt);
    bit [4:0] r;
    if (!m_is_branch()) return 2'b00;
    if (is_rt && !(ID_Opcode inside {6'd4, 6'd5})) return 2'b00;
    r = is_rt ? ID_Rt : ID_Rs;
    if (m_hit(MEM_RegWrite, MEM_Rd, r) && !MEM_MemRead) return 2'b01;
    if (m_hit(WB_RegWrite, WB_Rd, r)) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    bit busy;
    int left;
    bit e_st, e_res;
    bit [5:0] ops [8];
    ops = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd35};

    vt[0] = mk(1, 4, 3, 4, 0,0,0, 0,0,0, 0,0, 1,  0,1, 2'b00, 2'b00);
    vt[1] = mk(1, 1, 0, 0, 1,0,0, 0,0,0, 0,0, 0,  0,0, 2'b00, 2'b00);
    vt[2] = mk(1, 7, 1, 8, 1,0,8, 0,0,0, 0,0, 1,  0,1, 2'b00, 2'b00);
    vt[3] = mk(1, 0, 3, 3, 1,1,3, 0,0,0, 0,0, 1,  0,0, 2'b00, 2'b00);
    vt[4] = mk(0, 4, 2, 2, 0,0,0, 1,0,2, 0,0, 1,  0,0, 2'b00, 2'b00);
    vt[5] = mk(1, 4, 2, 3, 0,0,0, 1,0,3, 1,2, 1,  0,1, 2'b10, 2'b01);
    vt[6] = mk(1, 6, 4, 5, 0,0,0, 1,0,5, 1,4, 0,  0,0, 2'b10, 2'b00);
    vt[7] = mk(1, 5, 6, 7, 0,0,0, 1,1,7, 0,0, 1,  1,0, 2'b00, 2'b00);
    vt[8] = mk(1, 4, 9, 9, 1,0,9, 0,0,0, 1,9, 1,  1,0, 2'b10, 2'b10);
    vt[9] = mk(1, 5,10, 1, 0,0,0, 1,0,10,1,10,1,  0,1, 2'b01, 2'b00);

    // ---- reset: outputs forced low even with a hazarding branch in ID ----
    Rst = 0;
    clear_inputs();
    ID_Valid = 1; ID_Opcode = 4; ID_Rs = 5; ID_Rt = 6;
    EX_RegWrite = 1; EX_MemRead = 1; EX_Rd = 5;
    MEM_RegWrite = 1; MEM_Rd = 6; WB_RegWrite = 1; WB_Rd = 5; CmpOut = 1;
    repeat (2) @(negedge Clk);
    #2;
    check_outs("reset", 0, 0, 2'b00, 2'b00);
    chk("reset.TakenCnt", TakenCnt, 0);
    clear_inputs();
    Rst = 1;

    // ---- table-driven single-cycle vectors from IDLE ----
    foreach (vt[i]) begin
      @(negedge Clk);
      apply_vec(vt[i]);
      #2;
      check_outs($sformatf("vec%0d", i), vt[i].e_stall, vt[i].e_pc, vt[i].e_fa, vt[i].e_fb);
      if (!vt[i].e_stall && vt[i].e_pc) exp_taken++;
      @(negedge Clk);
      clear_inputs();
      repeat (3) @(negedge Clk);
      #2;
      chk($sformatf("vec%0d.TakenCnt", i), TakenCnt, exp_taken);
    end

    // ---- BNE with load in EX: two stall cycles, resolve on third ----
    @(negedge Clk);
    ID_Valid = 1; ID_Opcode = 5; ID_Rs = 5; ID_Rt = 6;
    EX_RegWrite = 1; EX_MemRead = 1; EX_Rd = 5;
    WB_RegWrite = 1; WB_Rd = 5; CmpOut = 1;
    #2 check_outs("bne.c1", 1, 0, 2'b10, 2'b00);
    @(negedge Clk); #2 check_outs("bne.c2", 1, 0, 2'b10, 2'b00);
    @(negedge Clk); #2 check_outs("bne.c3", 0, 1, 2'b10, 2'b00);
    exp_taken++;
    @(negedge Clk);
    clear_inputs();
    #2 chk("bne.TakenCnt", TakenCnt, exp_taken);
    check_outs("bne.idle", 0, 0, 2'b00, 2'b00);

    // ---- BGTZ with ALU producer in EX: one stall, MEM forward in RESOLVE ----
    @(negedge Clk);
    ID_Valid = 1; ID_Opcode = 7; ID_Rs = 8; ID_Rt = 0;
    EX_RegWrite = 1; EX_Rd = 8; CmpOut = 0;
    #2 check_outs("bgtz.c1", 1, 0, 2'b00, 2'b00);
    @(negedge Clk);
    EX_RegWrite = 0; MEM_RegWrite = 1; MEM_Rd = 8; MEM_MemRead = 0;
    #2 check_outs("bgtz.c2", 0, 0, 2'b01, 2'b00);
    @(negedge Clk);
    clear_inputs();
    #2 chk("bgtz.TakenCnt", TakenCnt, exp_taken);

    // ---- async reset during a 2-cycle stall ----
    @(negedge Clk);
    ID_Valid = 1; ID_Opcode = 4; ID_Rs = 7; ID_Rt = 2;
    EX_RegWrite = 1; EX_MemRead = 1; EX_Rd = 7; CmpOut = 1;
    @(negedge Clk);
    #2 chk("rststall.pre", Stall, 1);
    Rst = 0;
    #1 check_outs("rststall.async", 0, 0, 2'b00, 2'b00);
    chk("rststall.TakenCnt", TakenCnt, 0);
    exp_taken = 0;
    @(negedge Clk);
    clear_inputs();
    Rst = 1;
    // back in IDLE: a hazard-free taken branch resolves immediately
    @(negedge Clk);
    ID_Valid = 1; ID_Opcode = 4; ID_Rs = 3; ID_Rt = 4; CmpOut = 1;
    #2 check_outs("postrst.c1", 0, 1, 2'b00, 2'b00);
    @(negedge Clk);
    ID_Valid = 0;
    #2 check_outs("postrst.c2", 0, 0, 2'b00, 2'b00);
    chk("postrst.TakenCnt", TakenCnt, 1);

    // ---- randomized run against the reference model ----
    @(negedge Clk);
    Rst = 0;
    #1;
    Rst = 1;
    exp_taken = 0;
    busy = 0; left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      ID_Valid     = ($urandom_range(3) != 0);
      ID_Opcode    = ops[$urandom_range(7)];
      ID_IBit16    = $urandom_range(1);
      ID_Rs        = $urandom_range(3);
      ID_Rt        = $urandom_range(3);
      EX_RegWrite  = $urandom_range(1);
      EX_MemRead   = $urandom_range(1);
      EX_Rd        = $urandom_range(3);
      MEM_RegWrite = $urandom_range(1);
      MEM_MemRead  = $urandom_range(1);
      MEM_Rd       = $urandom_range(3);
      WB_RegWrite  = $urandom_range(1);
      WB_Rd        = $urandom_range(3);
      CmpOut       = $urandom_range(1);
      #2;
      e_st = 0; e_res = 0;
      if (!busy) begin
        if (m_is_branch()) begin
          if (m_stalls() == 0) e_res = 1;
          else e_st = 1;
        end
      end else if (left > 0) begin
        e_st = 1;
      end else begin
        e_res = 1;
      end
      check_outs($sformatf("rnd%0d", c), e_st, e_res && CmpOut, m_fwd(0), m_fwd(1));
      chk($sformatf("rnd%0d.TakenCnt", c), TakenCnt, exp_taken);
      // state advance at the coming rising edge
      if (!busy) begin
        if (e_st) begin busy = 1; left = m_stalls() - 1; end
      end else if (left > 0) begin
        left--;
      end else begin
        busy = 0;
      end
      if (e_res && CmpOut && exp_taken < 65535) exp_taken++;
    end

    // ---- saturation of the taken counter ----
    @(negedge Clk);
    clear_inputs();
    Rst = 0;
    #1;
    Rst = 1;
    ID_Valid = 1; ID_Opcode = 4; ID_Rs = 3; ID_Rt = 4; CmpOut = 1;
    repeat (65535) @(negedge Clk);
    #2 chk("sat.full", TakenCnt, 16'hFFFF);
    chk("sat.pc", PCSrc, 1);
    @(negedge Clk);
    #2 chk("sat.hold", TakenCnt, 16'hFFFF);
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
